// File: rtl/seven_seg_digit_scanner.sv
// Scan controller feeding a seven-segment decoder: walks the digits, one slot each REFRESH_DIV clocks.
// Outputs are registered one cycle behind idx; value loads are double-buffered and committed at frame wrap.
module seven_seg_digit_scanner #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    lz_blank,
  output logic [3:0]              BCD,
  output logic                    seg_blank,
  output logic                    dp_n,
  output logic [N_DIGITS-1:0]     digit_an,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);

  logic [CW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*N_DIGITS-1:0]   disp_val;
  logic [N_DIGITS-1:0]     disp_dp;
  logic [4*N_DIGITS-1:0]   shadow_val;
  logic [N_DIGITS-1:0]     shadow_dp;
  logic                    pending;

  logic                    tick;
  logic                    wrap;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    zero_above;

  assign tick = (presc == CW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx == IW'(N_DIGITS - 1));

  // zero_above accumulates from the MS digit down, so it is true at digit i
  // exactly when nibbles i..N_DIGITS-1 are all zero.
  always_comb begin
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (disp_val[4*i +: 4] == 4'd0);
      if (idx == IW'(i)) begin
        cur_nib   = disp_val[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_blank = lz_blank && (i != 0) && zero_above;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      BCD        <= '0;
      seg_blank  <= 1'b1;
      dp_n       <= 1'b1;
      digit_an   <= '1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;

      if (wrap && pending) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
      end
      // A load on the wrap edge lands in the shadow and stays pending for the next frame.
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end

      frame_done <= wrap;
      BCD        <= cur_nib;
      seg_blank  <= cur_blank;
      dp_n       <= cur_blank | ~cur_dp;
      digit_an   <= cur_blank ? '1 : ~(N_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seven_seg_digit_scanner.sv
// Directed bench for seven_seg_digit_scanner with N_DIGITS=4, REFRESH_DIV=4 (16-cycle frames).
module tb_seven_seg_digit_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_blank = 1'b0;
  logic [3:0]  BCD;
  logic        seg_blank;
  logic        dp_n;
  logic [3:0]  digit_an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int ncyc;

  seven_seg_digit_scanner #(.N_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .lz_blank(lz_blank), .BCD(BCD), .seg_blank(seg_blank), .dp_n(dp_n),
    .digit_an(digit_an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"},    32'(digit_an),   32'hF);
    chk({tag, "_blank"}, 32'(seg_blank),  32'h1);
    chk({tag, "_dpn"},   32'(dp_n),       32'h1);
    chk({tag, "_bcd"},   32'(BCD),        32'h0);
    chk({tag, "_fd"},    32'(frame_done), 32'h0);
  endtask

  // Returns at the negedge where frame_done is seen high; n = negedges waited.
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 40);
    if (!frame_done) chk("frame_timeout", 32'h0, 32'h1);
  endtask

  // Called at a frame_done negedge (or right after reset release); samples slots 0..3
  // one negedge after each slot starts. Ends 3 cycles before the next wrap edge.
  task automatic check_frame(input string tag, input logic [15:0] bcd_e, input logic [15:0] an_e,
                             input logic [3:0] dpn_e, input logic [3:0] blank_e);
    for (int s = 0; s < 4; s++) begin
      repeat (s == 0 ? 1 : 4) @(negedge clk);
      chk($sformatf("%s_s%0d_bcd", tag, s),   32'(BCD),       32'(bcd_e[4*s +: 4]));
      chk($sformatf("%s_s%0d_an", tag, s),    32'(digit_an),  32'(an_e[4*s +: 4]));
      chk($sformatf("%s_s%0d_dpn", tag, s),   32'(dp_n),      32'(dpn_e[s]));
      chk($sformatf("%s_s%0d_blank", tag, s), 32'(seg_blank), 32'(blank_e[s]));
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    load  = 1'b1;
    value = v;
    dp_in = dp;
  endtask

  localparam logic [15:0] AN_SCAN = 16'b0111_1011_1101_1110;

  initial begin
    // 1: reset state, first frame after release and frame period
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    check_frame("t1", 16'h0000, AN_SCAN, 4'b1111, 4'b0000);
    wait_frame(ncyc);
    chk("t1_first_fd_cycle", 32'(ncyc), 32'd3);
    wait_frame(ncyc);
    chk("t1_fd_period", 32'(ncyc), 32'd16);
    check_frame("t1b", 16'h0000, AN_SCAN, 4'b1111, 4'b0000);

    // 2: mid-frame load is invisible until the wrap, then hex/dp show through
    do_load(16'h12A9, 4'b0100);
    @(negedge clk);
    load = 1'b0;
    chk("t2_pre_commit_bcd", 32'(BCD), 32'h0);
    chk("t2_pre_commit_an", 32'(digit_an), 32'b0111);
    wait_frame(ncyc);
    check_frame("t2", 16'h12A9, AN_SCAN, 4'b1011, 4'b0000);

    // 3: leading-zero blanking
    lz_blank = 1'b1;
    do_load(16'h0045, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    wait_frame(ncyc);
    check_frame("t3a", 16'h0045, 16'b1111_1111_1101_1110, 4'b1111, 4'b1100);
    do_load(16'h0000, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    wait_frame(ncyc);
    check_frame("t3b", 16'h0000, 16'b1111_1111_1111_1110, 4'b1111, 4'b1110);
    lz_blank = 1'b0;

    // 5: 2222 pending, 3333 loaded on the exact wrap edge
    @(negedge clk);
    do_load(16'h2222, 4'b0000);
    @(negedge clk);
    do_load(16'h3333, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    chk("t5_fd_on_load_edge", 32'(frame_done), 32'h1);
    check_frame("t5a", 16'h2222, AN_SCAN, 4'b1111, 4'b0000);
    wait_frame(ncyc);
    check_frame("t5b", 16'h3333, AN_SCAN, 4'b1111, 4'b0000);

    // 4: two loads in one frame, last wins
    do_load(16'h1111, 4'b0000);
    @(negedge clk);
    do_load(16'h2222, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    wait_frame(ncyc);
    check_frame("t4", 16'h2222, AN_SCAN, 4'b1111, 4'b0000);

    // 6: reset mid-frame with a load pending
    do_load(16'h4444, 4'b1111);
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("t6_rst");
    rst_n = 1'b1;
    check_frame("t6a", 16'h0000, AN_SCAN, 4'b1111, 4'b0000);
    wait_frame(ncyc);
    chk("t6_fd_cycle", 32'(ncyc), 32'd3);
    check_frame("t6b", 16'h0000, AN_SCAN, 4'b1111, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
